// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared FSM states and line-state constants for the full-speed USB receive path
package usb_rx_pkg;
    typedef enum logic [2:0] {WAIT_IDLE, IDLE, SYNC, RECEIVE, EOP} rx_state_t;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;
    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam int STUFF_LIMIT = 6;
endpackage

// File: rtl/usb_rx_bit_timer.sv
// usb_rx_bit_timer: synchronises D+/D-, detects line-state changes and strobes once per bit at mid-bit
//   clk, n_rst          clock, asynchronous active-low reset
//   d_plus, d_minus     raw bus lines, asynchronous to clk
//   line_state          synchronised {D+, D-}
//   line_edge           line_state differs from the previous cycle
//   sample              mid-bit sample strobe
module usb_rx_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus,
    input  logic       d_minus,
    output logic [1:0] line_state,
    output logic       line_edge,
    output logic       sample
);
    import usb_rx_pkg::*;
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [1:0] meta, last;
    logic [CW-1:0] cnt, phase;
    // the cycle in which a change is seen is treated as phase 0 of the new bit
    assign line_edge = line_state != last;
    assign phase = line_edge ? '0 : cnt;
    assign sample = phase == CW'(CLKS_PER_BIT / 2 - 1);
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            meta <= LS_J;
            line_state <= LS_J;
            last <= LS_J;
            cnt <= '0;
        end else begin
            meta <= {d_plus, d_minus};
            line_state <= meta;
            last <= line_state;
            cnt <= (phase == CW'(CLKS_PER_BIT - 1)) ? '0 : phase + 1'b1;
        end
endmodule

// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder: full-speed USB receive front end (NRZI decode, unstuff, SYNC check, EOP detect, bytes)
//   clk, n_rst          clock, asynchronous active-low reset
//   dPlus_in, dMinus_in raw bus lines
//   rx_byte             last received byte, bit 0 first on the wire
//   rx_byte_valid       one-cycle strobe, rx_byte updated
//   rx_sop / rx_eop     one-cycle strobes for valid SYNC / completed EOP
//   rx_error            level, set on any error, cleared by the next rx_sop
//   rx_busy             high from the first K edge until the return to IDLE
module usb_rx_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int IDLE_BITS = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       dPlus_in,
    input  logic       dMinus_in,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       rx_sop,
    output logic       rx_eop,
    output logic       rx_error,
    output logic       rx_busy
);
    import usb_rx_pkg::*;
    localparam int IDLE_CLKS = IDLE_BITS * CLKS_PER_BIT;
    localparam int IW = $clog2(IDLE_CLKS);
    rx_state_t state, state_d;
    logic [1:0] line_state, prev, prev_d;
    logic line_edge, sample, bit_val, se0_seen, se0_d;
    logic [2:0] ones, ones_d, bits, bits_d;
    logic [7:0] sr, sr_d, shifted, byte_d;
    logic [IW-1:0] idle_cnt, idle_d;
    logic valid_d, sop_d, eop_d, err_d, busy_d;

    usb_rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) timer (
        .clk(clk), .n_rst(n_rst), .d_plus(dPlus_in), .d_minus(dMinus_in),
        .line_state(line_state), .line_edge(line_edge), .sample(sample)
    );

    assign bit_val = line_state == prev;
    assign shifted = {bit_val, sr[7:1]};

    always_comb begin
        state_d = state;
        prev_d = prev;
        ones_d = ones;
        bits_d = bits;
        sr_d = sr;
        se0_d = se0_seen;
        idle_d = '0;
        byte_d = rx_byte;
        valid_d = 1'b0;
        sop_d = 1'b0;
        eop_d = 1'b0;
        err_d = rx_error;
        busy_d = rx_busy;
        case (state)
            WAIT_IDLE: begin
                idle_d = (line_edge || line_state != LS_J) ? '0 : idle_cnt + 1'b1;
                if (!line_edge && line_state == LS_J && idle_cnt == IW'(IDLE_CLKS - 1)) begin
                    state_d = IDLE;
                    idle_d = '0;
                    busy_d = 1'b0;
                end
            end
            IDLE: if (line_state == LS_K) begin
                state_d = SYNC;
                busy_d = 1'b1;
                prev_d = LS_J;
                ones_d = '0;
                bits_d = '0;
            end
            SYNC: if (sample) begin
                if (line_state == LS_J || line_state == LS_K) begin
                    prev_d = line_state;
                    sr_d = shifted;
                    bits_d = bits + 3'd1;
                    ones_d = bit_val ? ones + 3'd1 : 3'd0;
                    if (bits == 3'd7) begin
                        state_d = (shifted == SYNC_PATTERN) ? RECEIVE : WAIT_IDLE;
                        sop_d = shifted == SYNC_PATTERN;
                        err_d = shifted != SYNC_PATTERN;
                    end
                end else begin
                    state_d = WAIT_IDLE;
                    err_d = 1'b1;
                end
            end
            RECEIVE: if (sample) begin
                if (line_state == LS_SE0) begin
                    state_d = EOP;
                    se0_d = 1'b0;
                end else if (line_state == LS_SE1) begin
                    state_d = WAIT_IDLE;
                    err_d = 1'b1;
                end else begin
                    prev_d = line_state;
                    ones_d = bit_val ? ones + 3'd1 : 3'd0;
                    // after a run of six ones this sample is a stuffed 0 and never joins the byte
                    if (ones == 3'(STUFF_LIMIT)) begin
                        if (bit_val) begin
                            state_d = WAIT_IDLE;
                            err_d = 1'b1;
                        end
                    end else begin
                        sr_d = shifted;
                        bits_d = bits + 3'd1;
                        if (bits == 3'd7) begin
                            byte_d = shifted;
                            valid_d = 1'b1;
                        end
                    end
                end
            end
            EOP: if (sample) begin
                if (line_state == LS_SE0 && !se0_seen) begin
                    se0_d = 1'b1;
                end else if (line_state == LS_J && se0_seen) begin
                    state_d = IDLE;
                    eop_d = 1'b1;
                    busy_d = 1'b0;
                    // a partial byte is dropped but flagged
                    err_d = rx_error || bits != 3'd0;
                end else begin
                    state_d = WAIT_IDLE;
                    err_d = 1'b1;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            state <= WAIT_IDLE;
            prev <= LS_J;
            ones <= '0;
            bits <= '0;
            sr <= '0;
            se0_seen <= 1'b0;
            idle_cnt <= '0;
            rx_byte <= '0;
            rx_byte_valid <= 1'b0;
            rx_sop <= 1'b0;
            rx_eop <= 1'b0;
            rx_error <= 1'b0;
            rx_busy <= 1'b0;
        end else begin
            state <= state_d;
            prev <= prev_d;
            ones <= ones_d;
            bits <= bits_d;
            sr <= sr_d;
            se0_seen <= se0_d;
            idle_cnt <= idle_d;
            rx_byte <= byte_d;
            rx_byte_valid <= valid_d;
            rx_sop <= sop_d;
            rx_eop <= eop_d;
            rx_error <= err_d;
            rx_busy <= busy_d;
        end
endmodule

// File: tb/tb_usb_rx_decoder.sv
// tb_usb_rx_decoder: randomized self-checking bench for usb_rx_decoder
module tb_usb_rx_decoder;
    localparam int CPB = 8;
    localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;
    localparam logic [1:0] EV_SOP = 2'd0, EV_BYTE = 2'd1, EV_EOP = 2'd2;
    typedef struct packed { logic [1:0] kind; logic [7:0] data; } ev_t;

    logic clk = 1'b0, n_rst = 1'b0, dp = 1'b1, dm = 1'b0;
    logic [7:0] rx_byte;
    logic rx_byte_valid, rx_sop, rx_eop, rx_error, rx_busy;
    int errors = 0, checks = 0, jprev = 0, ones_run = 0;
    bit jitter_on = 1'b0, exp_err = 1'b0;
    bit wire_q[$];
    ev_t exp_q[$];
    logic [7:0] pay_q[$], got_q[$];

    usb_rx_decoder #(.CLKS_PER_BIT(CPB), .IDLE_BITS(8)) dut (
        .clk(clk), .n_rst(n_rst), .dPlus_in(dp), .dMinus_in(dm),
        .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .rx_sop(rx_sop),
        .rx_eop(rx_eop), .rx_error(rx_error), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    function automatic ev_t ev(input logic [1:0] k, input logic [7:0] d);
        ev = {k, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic take_ev(input logic [1:0] kind, input logic [7:0] data, input string name);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected strobe data=%02h with no event expected", name, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data != data) begin
                errors++;
                $display("FAIL %s: got kind=%0d data=%02h required kind=%0d data=%02h",
                         name, kind, data, e.kind, e.data);
            end
        end
    endtask

    // every strobe must match the next event the model predicted
    always @(negedge clk) if (n_rst) begin
        if (rx_sop) take_ev(EV_SOP, 8'h00, "sop");
        if (rx_byte_valid) begin
            take_ev(EV_BYTE, rx_byte, "byte");
            got_q.push_back(rx_byte);
        end
        if (rx_eop) take_ev(EV_EOP, 8'h00, "eop");
    end

    task automatic outputs_zero(input string name);
        check({name, "_byte"}, rx_byte, 0);
        check({name, "_valid"}, rx_byte_valid, 0);
        check({name, "_sop"}, rx_sop, 0);
        check({name, "_eop"}, rx_eop, 0);
        check({name, "_error"}, rx_error, 0);
        check({name, "_busy"}, rx_busy, 0);
    endtask

    task automatic drive_sym(input logic [1:0] s);
        int jn;
        jn = jitter_on ? int'($urandom_range(2)) - 1 : 0;
        {dp, dm} = s;
        repeat (CPB + jn - jprev) @(negedge clk);
        jprev = jn;
    endtask

    task automatic add_bit(input bit b);
        wire_q.push_back(b);
        ones_run = b ? ones_run + 1 : 0;
        if (ones_run == 6) begin
            wire_q.push_back(1'b0);
            ones_run = 0;
        end
    endtask

    task automatic add_byte(input logic [7:0] x);
        for (int i = 0; i < 8; i++) add_bit(x[i]);
    endtask

    task automatic start_packet(input logic [7:0] sync_byte);
        wire_q.delete();
        ones_run = 0;
        add_byte(sync_byte);
    endtask

    task automatic mid_reset();
        check("busy_before_reset", rx_busy, 1);
        #2 n_rst = 1'b0;
        #1 outputs_zero("mid_reset");
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic send_packet(input int rst_at);
        logic [1:0] lvl;
        lvl = J;
        for (int i = 0; i < wire_q.size(); i++) begin
            if (i == rst_at) mid_reset();
            if (!wire_q[i]) lvl = (lvl == J) ? K : J;
            drive_sym(lvl);
        end
        drive_sym(SE0);
        drive_sym(SE0);
        repeat (12) drive_sym(J);
    endtask

    task automatic end_pkt(input string name);
        check({name, "_missing_events"}, exp_q.size(), 0);
        check({name, "_error"}, rx_error, exp_err);
        check({name, "_busy"}, rx_busy, 0);
        exp_q.delete();
    endtask

    task automatic good_packet(input string name, input int partial);
        start_packet(8'h80);
        exp_q.push_back(ev(EV_SOP, 8'h00));
        foreach (pay_q[i]) begin
            add_byte(pay_q[i]);
            exp_q.push_back(ev(EV_BYTE, pay_q[i]));
        end
        for (int i = 0; i < partial; i++) add_bit(1'($urandom));
        exp_q.push_back(ev(EV_EOP, 8'h00));
        exp_err = partial != 0;
        send_packet(-1);
        end_pkt(name);
    endtask

    function automatic logic [7:0] got_at(input int i);
        got_at = (i >= 0 && i < got_q.size()) ? got_q[i] : 8'hxx;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        n_rst = 1'b1;
        repeat (10) drive_sym(J);

        start_packet(8'h80);
        add_byte(8'hFF);
        check("stuffed_len_sync_ff", wire_q.size(), 17);

        for (int pass = 0; pass < 2; pass++) begin
            jitter_on = pass[0];
            got_q.delete();
            pay_q = '{8'hA5, 8'h3C};
            good_packet("s1_two_bytes", 0);
            check("s1_byte_count", got_q.size(), 2);
            check("s1_first", got_at(0), 8'hA5);
            check("s1_second", got_at(1), 8'h3C);
        end

        got_q.delete();
        pay_q = '{8'hFF};
        good_packet("s2_ff", 0);
        check("s2_byte", got_at(0), 8'hFF);

        start_packet(8'h80);
        add_byte(8'h12);
        wire_q.push_back(1'b0);
        repeat (7) wire_q.push_back(1'b1);
        exp_q.push_back(ev(EV_SOP, 8'h00));
        exp_q.push_back(ev(EV_BYTE, 8'h12));
        exp_err = 1'b1;
        send_packet(-1);
        end_pkt("s3_stuff_violation");

        got_q.delete();
        pay_q = '{8'h5A};
        good_packet("s4_partial", 4);
        check("s4_byte_count", got_q.size(), 1);

        start_packet(8'hC0);
        add_byte(8'h33);
        exp_err = 1'b1;
        send_packet(-1);
        end_pkt("s5_bad_sync");
        pay_q = '{8'($urandom)};
        good_packet("s5_recover", 0);

        start_packet(8'h80);
        add_byte(8'h96);
        add_byte(8'h41);
        exp_q.push_back(ev(EV_SOP, 8'h00));
        exp_err = 1'b0;
        send_packet(12);
        end_pkt("s6_reset_mid_byte");
        pay_q = '{8'hC3, 8'h7E};
        good_packet("s6_after_reset", 0);

        for (int n = 0; n < 10; n++) begin
            jitter_on = 1'($urandom);
            pay_q.delete();
            repeat ($urandom_range(3)) pay_q.push_back(8'($urandom));
            good_packet("rand", ($urandom_range(3) == 0) ? int'($urandom_range(7, 1)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
